// File: rtl/dvbs2_bpsk_seq_pkg.sv
// Shared symbol-type codes, sequencer states and PLFRAME block lengths
// for the DVB-S2 BPSK 1/3 short-frame sequencer.
package dvbs2_bpsk_seq_pkg;

    localparam logic [1:0] SYM_DATA  = 2'd0;
    localparam logic [1:0] SYM_HDR   = 2'd1;
    localparam logic [1:0] SYM_PILOT = 2'd2;
    localparam logic [1:0] SYM_DUMMY = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        DATA,
        PILOT,
        DUMMY
    } seq_state_t;

    localparam int HDR_LEN      = 90;
    localparam int SLOT_LEN     = 90;
    localparam int PILOT_PERIOD = 16;
    localparam int PILOT_LEN    = 36;
    localparam int DUMMY_LEN    = 3240;
    localparam int IDLE_LIMIT   = 4095;

endpackage

// File: rtl/dvbs2_bpsk_slot_counter.sv
// Data-symbol counter and pilot-period counter for one PLFRAME; flags the
// final data symbol and transfers that close a pilot period.
module dvbs2_bpsk_slot_counter
    import dvbs2_bpsk_seq_pkg::*;
#(
    parameter int FRAME_BITS  = 16200,
    parameter int PERIOD_SYMS = PILOT_PERIOD * SLOT_LEN
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic advance,
    output logic last,
    output logic pilot_due
);

    localparam int DW = $clog2(FRAME_BITS);
    localparam int SW = $clog2(PERIOD_SYMS);

    logic [DW-1:0] dcnt;
    logic [SW-1:0] scnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dcnt <= '0;
            scnt <= '0;
        end else if (clear || (advance && last)) begin
            dcnt <= '0;
            scnt <= '0;
        end else if (advance) begin
            dcnt <= dcnt + 1'b1;
            scnt <= (scnt == SW'(PERIOD_SYMS - 1)) ? '0 : scnt + 1'b1;
        end
    end

    assign last      = (dcnt == DW'(FRAME_BITS - 1));
    // The final symbol never opens a pilot block even if it closes a period.
    assign pilot_due = (scnt == SW'(PERIOD_SYMS - 1)) && !last;

endmodule

// File: rtl/dvbs2_bpsk_frame_sequencer.sv
// Drives the BPSK buffer-input address generator through header, data and
// pilot phases of a short PLFRAME. Optional dummy frames: DVBS2_BPSK_DUMMY_FRAME_EN.
module dvbs2_bpsk_frame_sequencer
    import dvbs2_bpsk_seq_pkg::*;
#(
    parameter int FRAME_BITS = 16200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enb,
    input  logic       frameStart,
    input  logic       pilotsOn,
    input  logic       dataIn,
    input  logic       validIn,
    output logic       readyOut,
    output logic       addrData,
    output logic       addrValid,
    output logic       addrReset,
    output logic [1:0] symType,
    output logic [6:0] symIdx,
    output logic       frameDone,
    output logic       errOut
);

    localparam int BW = 12;

    seq_state_t     state, state_nxt, header_exit;
    logic [BW-1:0]  bcnt, bcnt_nxt;
    logic           pilots_lat, pilots_nxt;
    logic           data_nxt, valid_nxt, rst_nxt, done_nxt, err_nxt;
    logic [1:0]     type_nxt;
    logic [6:0]     idx_nxt;
    logic           transfer, accept, dummy_go, cnt_clear;
    logic           last, pilot_due;

    assign readyOut = (state == DATA);
    assign transfer = validIn && readyOut && enb;
    // A frameStart arriving with the previous frame's frameDone is rejected.
    assign accept   = enb && frameStart && (state == IDLE) && !frameDone;

`ifdef DVBS2_BPSK_DUMMY_FRAME_EN
    logic [15:0] idle_cnt;
    logic        dummy_lat;

    assign dummy_go    = enb && (state == IDLE) && !frameStart &&
                         (idle_cnt == 16'(IDLE_LIMIT - 1));
    assign header_exit = dummy_lat ? DUMMY : DATA;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt  <= '0;
            dummy_lat <= 1'b0;
        end else if (enb) begin
            if (state != IDLE || frameStart || dummy_go)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;
            if (state == IDLE)
                dummy_lat <= dummy_go;
        end
    end
`else
    assign dummy_go    = 1'b0;
    assign header_exit = DATA;
`endif

    dvbs2_bpsk_slot_counter #(
        .FRAME_BITS (FRAME_BITS)
    ) u_slot_counter (
        .clk       (clk),
        .reset     (reset),
        .clear     (cnt_clear && enb),
        .advance   (transfer),
        .last      (last),
        .pilot_due (pilot_due)
    );

    always_comb begin
        state_nxt  = state;
        bcnt_nxt   = bcnt;
        pilots_nxt = pilots_lat;
        data_nxt   = 1'b0;
        valid_nxt  = 1'b0;
        rst_nxt    = 1'b0;
        type_nxt   = SYM_DATA;
        idx_nxt    = '0;
        done_nxt   = 1'b0;
        err_nxt    = frameStart && !accept;
        cnt_clear  = 1'b0;
        case (state)
            IDLE: begin
                if (accept || dummy_go) begin
                    state_nxt  = HEADER;
                    pilots_nxt = accept ? pilotsOn : 1'b0;
                    bcnt_nxt   = BW'(1);
                    rst_nxt    = 1'b1;
                    valid_nxt  = 1'b1;
                    type_nxt   = SYM_HDR;
                    cnt_clear  = 1'b1;
                end
            end
            HEADER: begin
                valid_nxt = 1'b1;
                type_nxt  = SYM_HDR;
                idx_nxt   = bcnt[6:0];
                bcnt_nxt  = bcnt + 1'b1;
                if (bcnt == BW'(HDR_LEN - 1)) begin
                    bcnt_nxt  = '0;
                    state_nxt = header_exit;
                end
            end
            DATA: begin
                if (transfer) begin
                    valid_nxt = 1'b1;
                    data_nxt  = dataIn;
                    if (last) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else if (pilots_lat && pilot_due) begin
                        state_nxt = PILOT;
                    end
                end
            end
            PILOT: begin
                valid_nxt = 1'b1;
                type_nxt  = SYM_PILOT;
                idx_nxt   = bcnt[6:0];
                bcnt_nxt  = bcnt + 1'b1;
                if (bcnt == BW'(PILOT_LEN - 1)) begin
                    bcnt_nxt  = '0;
                    state_nxt = DATA;
                end
            end
`ifdef DVBS2_BPSK_DUMMY_FRAME_EN
            DUMMY: begin
                valid_nxt = 1'b1;
                type_nxt  = SYM_DUMMY;
                bcnt_nxt  = bcnt + 1'b1;
                if (bcnt == BW'(DUMMY_LEN - 1)) begin
                    bcnt_nxt  = '0;
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bcnt       <= '0;
            pilots_lat <= 1'b0;
            addrData   <= 1'b0;
            addrValid  <= 1'b0;
            addrReset  <= 1'b0;
            symType    <= SYM_DATA;
            symIdx     <= '0;
            frameDone  <= 1'b0;
            errOut     <= 1'b0;
        end else if (enb) begin
            state      <= state_nxt;
            bcnt       <= bcnt_nxt;
            pilots_lat <= pilots_nxt;
            addrData   <= data_nxt;
            addrValid  <= valid_nxt;
            addrReset  <= rst_nxt;
            symType    <= type_nxt;
            symIdx     <= idx_nxt;
            frameDone  <= done_nxt;
            errOut     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_dvbs2_bpsk_frame_sequencer.sv
// Bench for dvbs2_bpsk_frame_sequencer: expected PLFRAME symbol stream is
// built from the frame layout rules and compared against the generator outputs.
module tb_dvbs2_bpsk_frame_sequencer;

    localparam int FRAME = 16200;

    logic       clk = 1'b0;
    logic       reset, enb, frameStart, pilotsOn, dataIn, validIn;
    logic       readyOut, addrData, addrValid, addrReset, frameDone, errOut;
    logic [1:0] symType;
    logic [6:0] symIdx;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0] t;
        int         idx;
        logic       d;
        logic       rst;
        logic       done;
    } sym_t;

    typedef struct {
        bit pil;
        int gap;
        int enbp;
        bit inj;
        int exp_valid;
        int exp_rlow;
        int exp_err;
    } vec_t;

    sym_t expq[$];
    bit   bits[0:FRAME-1];
    vec_t tbl[4];

    dvbs2_bpsk_frame_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .enb        (enb),
        .frameStart (frameStart),
        .pilotsOn   (pilotsOn),
        .dataIn     (dataIn),
        .validIn    (validIn),
        .readyOut   (readyOut),
        .addrData   (addrData),
        .addrValid  (addrValid),
        .addrReset  (addrReset),
        .symType    (symType),
        .symIdx     (symIdx),
        .frameDone  (frameDone),
        .errOut     (errOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic logic [13:0] outs();
        return {addrData, addrValid, addrReset, symType, symIdx, frameDone, errOut};
    endfunction

    task automatic note_bad(inout int b, inout int fb, input int c);
        b++;
        if (fb < 0) fb = c;
    endtask

    // Frame layout: 90 header markers, data bits, 36 pilots after each 1440 data symbols unless last.
    task automatic build_expected(input bit pil);
        expq.delete();
        for (int i = 0; i < FRAME; i++) bits[i] = 1'($urandom_range(1));
        for (int h = 0; h < 90; h++) expq.push_back('{2'd1, h, 1'b0, h == 0, 1'b0});
        for (int i = 0; i < FRAME; i++) begin
            expq.push_back('{2'd0, 0, bits[i], 1'b0, i == FRAME - 1});
            if (pil && ((i + 1) % 1440 == 0) && (i + 1 < FRAME))
                for (int p = 0; p < 36; p++) expq.push_back('{2'd2, p, 1'b0, 1'b0, 1'b0});
        end
    endtask

    task automatic run_frame(input bit pil, input int gap, input int enbp, input bit inj,
                             input int stop_at, output int nvalid, output int ndone,
                             output int nrst, output int rlow, output int nerr_out,
                             output int bad, output int first_bad);
        int pos, k, cyc, ndata;
        bit fin, xfer, inj_h, inj_d;
        logic drv_v, drv_e, rdy, exp_err;
        logic [13:0] snap;
        sym_t e;
        build_expected(pil);
        nvalid = 0; ndone = 0; nrst = 0; rlow = 0; nerr_out = 0; bad = 0; first_bad = -1;
        pos = 0; k = 0; cyc = 0; ndata = 0; fin = 0; inj_h = 0; inj_d = 0;
        frameStart = 1'b1; pilotsOn = pil; enb = 1'b1; validIn = 1'b0; dataIn = 1'b0;
        drv_v = 1'b0; drv_e = 1'b1; exp_err = 1'b0; rdy = readyOut; snap = outs();
        while (!fin && cyc < 60000) begin
            @(posedge clk); #1;
            cyc++;
            xfer = drv_v && rdy && drv_e;
            if (xfer) k++;
            if (drv_e) begin
                if (errOut !== exp_err) note_bad(bad, first_bad, cyc);
                if (errOut) nerr_out++;
                if (addrValid) begin
                    nvalid++;
                    if (addrReset) nrst++;
                    if (frameDone) ndone++;
                    if (pos < expq.size()) begin
                        e = expq[pos];
                        if (symType !== e.t || int'(symIdx) != e.idx || addrData !== e.d ||
                            addrReset !== e.rst || frameDone !== e.done)
                            note_bad(bad, first_bad, cyc);
                    end else begin
                        note_bad(bad, first_bad, cyc);
                    end
                    if (symType == 2'd0) ndata++;
                    pos++;
                end else if (addrReset || frameDone) begin
                    note_bad(bad, first_bad, cyc);
                end
                if (frameDone) fin = 1;
            end else if (outs() !== snap) begin
                note_bad(bad, first_bad, cyc);
            end
            snap = outs();
            if (ndata > 0 && !frameDone && !readyOut) rlow++;
            if (stop_at > 0 && ndata >= stop_at) fin = 1;
            rdy = readyOut;
            if (!fin) begin
                frameStart = 1'b0;
                exp_err = 1'b0;
                drv_e = int'($urandom_range(99)) >= enbp;
                if (!(drv_v && !xfer)) drv_v = (int'($urandom_range(99)) >= gap);
                if (k >= FRAME) drv_v = 1'b0;
                if (inj && !inj_h && pos >= 30) begin
                    frameStart = 1'b1; drv_e = 1'b1; exp_err = 1'b1; inj_h = 1;
                end else if (inj && !inj_d && pos >= 3000) begin
                    frameStart = 1'b1; drv_e = 1'b1; exp_err = 1'b1; inj_d = 1;
                end
                enb = drv_e;
                validIn = drv_v;
                dataIn = (k < FRAME) ? bits[k] : 1'b0;
            end
        end
        if (!fin) begin
            note_bad(bad, first_bad, -2);
        end else if (stop_at == 0) begin
            frameStart = inj; enb = 1'b1; validIn = 1'b0;
            @(posedge clk); #1;
            if (errOut !== inj) note_bad(bad, first_bad, -3);
            if (errOut) nerr_out++;
            if (addrValid || addrReset) note_bad(bad, first_bad, -4);
            frameStart = 1'b0;
        end
    endtask

    initial begin
        int nvalid, ndone, nrst, rlow, nerr, bad, fb;
        tbl[0] = '{1'b0, 0,  0,  1'b0, 16290, 0,   0};
        tbl[1] = '{1'b1, 0,  0,  1'b0, 16686, 396, 0};
        tbl[2] = '{1'b0, 10, 10, 1'b1, 16290, -1,  3};
        tbl[3] = '{1'b1, 10, 5,  1'b1, 16686, -1,  3};

        reset = 1'b1; enb = 1'b0; frameStart = 1'b0; pilotsOn = 1'b0;
        dataIn = 1'b0; validIn = 1'b0;
        #12;
        check("reset addrValid", int'(addrValid), 0);
        check("reset addrReset", int'(addrReset), 0);
        check("reset symType", int'(symType), 0);
        check("reset readyOut", int'(readyOut), 0);
        check("reset frameDone_errOut", int'({frameDone, errOut}), 0);
        @(negedge clk);
        reset = 1'b0; enb = 1'b1;
        @(posedge clk); #1;

        // frameStart while disabled is ignored outright
        frameStart = 1'b1; enb = 1'b0;
        @(posedge clk); #1;
        frameStart = 1'b0; enb = 1'b1;
        @(posedge clk); #1;
        check("enb0 start addrValid", int'(addrValid), 0);
        check("enb0 start errOut", int'(errOut), 0);
        check("enb0 start readyOut", int'(readyOut), 0);

        // abort a pilot frame at data symbol 5000 with an asynchronous reset
        run_frame(1'b1, 0, 0, 1'b0, 5000, nvalid, ndone, nrst, rlow, nerr, bad, fb);
        check($sformatf("partial stream first_bad=%0d", fb), bad, 0);
        #1;
        reset = 1'b1;
        #1;
        check("midreset addrValid", int'(addrValid), 0);
        check("midreset readyOut", int'(readyOut), 0);
        check("midreset symType_symIdx", int'({symType, symIdx}), 0);
        @(negedge clk);
        reset = 1'b0; frameStart = 1'b0; validIn = 1'b0; enb = 1'b1;
        @(posedge clk); #1;
        check("post reset idle addrValid", int'(addrValid), 0);

        for (int r = 0; r < 4; r++) begin
            run_frame(tbl[r].pil, tbl[r].gap, tbl[r].enbp, tbl[r].inj, 0,
                      nvalid, ndone, nrst, rlow, nerr, bad, fb);
            check($sformatf("row%0d valid_cycles", r), nvalid, tbl[r].exp_valid);
            check($sformatf("row%0d frameDone_count", r), ndone, 1);
            check($sformatf("row%0d addrReset_count", r), nrst, 1);
            check($sformatf("row%0d errOut_count", r), nerr, tbl[r].exp_err);
            check($sformatf("row%0d stream first_bad=%0d", r, fb), bad, 0);
            if (tbl[r].exp_rlow >= 0)
                check($sformatf("row%0d ready_low_cycles", r), rlow, tbl[r].exp_rlow);
        end

`ifdef DVBS2_BPSK_DUMMY_FRAME_EN
        begin
            int nr, nh, nd, rb;
            nr = 0; nh = 0; nd = 0; rb = 0;
            enb = 1'b1; frameStart = 1'b0; validIn = 1'b0;
            for (int c = 0; c < 7500; c++) begin
                @(posedge clk); #1;
                if (addrReset) nr++;
                if (addrValid && symType == 2'd1) nh++;
                if (addrValid && symType == 2'd3 && !addrData) nd++;
                if (readyOut) rb++;
            end
            check("dummy addrReset_count", nr, 1);
            check("dummy header_count", nh, 90);
            check("dummy symbol_count", nd, 3240);
            check("dummy readyOut_high", rb, 0);
            frameStart = 1'b1;
            @(posedge clk); #1;
            frameStart = 1'b0;
            check("after dummy start addrReset", int'(addrReset), 1);
            check("after dummy start errOut", int'(errOut), 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dvbs2_bpsk_frame_sequencer.md
Name: dvbs2_bpsk_frame_sequencer

Overview:
- Sequences one BPSK 1/3 short PLFRAME through the buffer-input address generator.
- On each frame start it pulses the generator's reset and emits 90 header-slot markers.
- It then admits FRAME_BITS data bits with ready/valid backpressure, opening 36-symbol pilot windows after every 16 data slots when pilots are enabled.
- Sits between the FEC/interleaver output and the BPSK address generator / symbol mapper.

Parameters:
- FRAME_BITS, 16200, data symbols per frame (short FECFRAME, BPSK).
- HDR_LEN, 90, PL header symbols.
- SLOT_LEN, 90, symbols per slot.
- PILOT_PERIOD, 16, data slots between pilot blocks.
- PILOT_LEN, 36, symbols per pilot block.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- enb  in  1  clock enable; when 0 all state and outputs hold
- frameStart  in  1  single-cycle frame request pulse
- pilotsOn  in  1  pilot enable, sampled when frameStart is accepted
- dataIn  in  1  data bit (ufix1)
- validIn  in  1  dataIn valid
- readyOut  out  1  upstream may transfer (combinational from state)
- addrData  out  1  bit to address generator (dataIn of generator)
- addrValid  out  1  validIn of generator
- addrReset  out  1  resetIn of generator, one-cycle pulse
- symType  out  2  0=data, 1=header, 2=pilot, 3=dummy
- symIdx  out  7  index within current header/pilot block, 0 for data
- frameDone  out  1  one-cycle pulse with last data symbol
- errOut  out  1  one-cycle pulse: frameStart rejected

Behaviour:
- All registered outputs reset to 0; state resets to IDLE; counters reset to 0.
- All state updates and transfers are qualified by enb.
- IDLE:
  - readyOut=0; addrValid=0.
  - frameStart latches pilotsOn into pilotsLat and enters HEADER.
  - Next cycle: addrReset=1 and first header marker (symType=1, symIdx=0, addrValid=1).
- HEADER:
  - 90 consecutive cycles, addrValid=1, symIdx 0..89, addrData=0, readyOut=0.
  - After symIdx=89 go to DATA.
- DATA:
  - readyOut=1.
  - Transfer = validIn & readyOut & enb.
  - Each transfer registers addrData=dataIn, addrValid=1, symType=0 on the next edge (latency 1).
  - No transfer gives addrValid=0.
  - Data counter dcnt (14 bit) and slot-symbol counter scnt increment per transfer.
  - Exactly one transfer at dcnt=FRAME_BITS-1 ends the frame: frameDone=1 with that symbol, next state IDLE.
- Pilot trigger:
  - Condition: pilotsLat=1 and a transfer completes a multiple of PILOT_PERIOD*SLOT_LEN=1440 data symbols, with data remaining.
  - Next state is PILOT; readyOut drops the following cycle.
  - Result: 11 pilot blocks per frame, after data symbols 1440, 2880, ..., 15840. No pilot after the final symbol.
- PILOT:
  - 36 cycles, addrValid=1, symType=2, symIdx 0..35, readyOut=0.
  - Then return to DATA.
- frameStart outside IDLE is ignored and pulses errOut, including frameStart in the cycle of frameDone.
- frameStart while enb=0 is ignored with no errOut.
- validIn with readyOut=0: bit is not consumed and upstream holds it.
- Mid-frame reset: immediate return to IDLE, outputs 0; the partial frame is discarded.
- Frame length with pilots: 90+16200+396=16686 output symbols; without pilots: 16290.

Optional Feature:
- Macro: DVBS2_BPSK_DUMMY_FRAME_EN.
- Defined:
  - A 16-bit idle counter runs in IDLE and clears on frameStart.
  - At 4095 idle cycles the block emits a dummy PLFRAME: addrReset pulse, 90 header markers (symType=1), then 3240 symbols with symType=3, addrData=0, addrValid=1, readyOut=0.
  - Then it returns to IDLE.
  - frameStart during a dummy frame pulses errOut.
- Undefined: the idle counter and DUMMY state are absent; symType=3 is never produced.

Decomposition:
- Package dvbs2_bpsk_seq_pkg holds:
  - symType encoding constants (SYM_DATA, SYM_HDR, SYM_PILOT, SYM_DUMMY).
  - State enum (IDLE, HEADER, DATA, PILOT, DUMMY).
  - HDR_LEN/SLOT_LEN/PILOT_LEN/DUMMY_LEN constants.
- Sub-module dvbs2_bpsk_slot_counter: data and slot counters with pilot-boundary and last-symbol flags.

Test Plan:
- Reset, then frameStart with pilotsOn=0 and continuous validIn:
  - addrReset exactly once, 90 header markers, 16200 data symbols in order, frameDone on symbol 16200.
  - Total 16290 valid cycles.
- frameStart with pilotsOn=1:
  - Pilot blocks of 36 begin after data symbols 1440·k, k=1..11.
  - readyOut=0 for those 36 cycles; 16686 valid cycles; no pilot after 16200.
- Random validIn gaps and enb toggling in DATA:
  - Output bit sequence equals input sequence.
  - addrValid only one cycle after a transfer; dcnt frozen while enb=0.
- frameStart in HEADER, DATA, and on the frameDone cycle:
  - errOut pulses each time; frame continues unaltered.
- reset asserted mid-DATA (symbol 5000), then a new frameStart:
  - Outputs clear immediately; new frame starts cleanly with addrReset.
- With DVBS2_BPSK_DUMMY_FRAME_EN, 4095 idle cycles:
  - Dummy frame of 90+3240 symbols with symType 1 then 3; a subsequent frameStart is accepted.
